// File: rtl/dmem_axi_bridge_pkg.sv
// Shared definitions for the dcache-to-AXI data bridge.
//   XLEN / ADDR_W / RESP_W : data, address and AXI response widths
//   ST_*                   : bridge FSM state encoding
//   AXI_RESP_OKAY          : the only response treated as success
package dmem_axi_bridge_pkg;

    localparam int XLEN   = 64;
    localparam int ADDR_W = 32;
    localparam int RESP_W = 2;
    localparam int STRB_W = XLEN / 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_ADDR = 3'd1;
    localparam logic [2:0] ST_RD_DATA = 3'd2;
    localparam logic [2:0] ST_WR_ADDR = 3'd3;
    localparam logic [2:0] ST_WR_RESP = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    localparam logic [RESP_W-1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/dmem_axi_bridge_align.sv
// Byte-lane alignment for one access (purely combinational).
//   off_i      : byte offset within the 8-byte beat (addr[2:0])
//   mask_i     : right-justified size mask (0x01/0x03/0x0F/0xFF)
//   wdata_i    : right-justified store data
//   rdata_i    : raw AXI read beat
//   strb_o     : write strobes, mask shifted to the offset
//   wdata_o    : store data shifted into its byte lanes
//   rdata_o    : read beat shifted down to bit 0 and trimmed to the size
//   misalign_o : access crosses its natural alignment
module dmem_align
    import dmem_axi_bridge_pkg::*;
(
    input  logic [2:0]        off_i,
    input  logic [STRB_W-1:0] mask_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XLEN-1:0]   rdata_i,
    output logic [STRB_W-1:0] strb_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic [XLEN-1:0]   rdata_o,
    output logic              misalign_o
);

    logic [XLEN-1:0] byte_mask;
    logic [3:0]      pop;
    logic [3:0]      size_m1;

    always_comb begin
        byte_mask = '0;
        pop       = '0;
        for (int i = 0; i < STRB_W; i++) begin
            byte_mask[8*i +: 8] = {8{mask_i[i]}};
            pop                 = pop + {3'b000, mask_i[i]};
        end
        // A size-N access is aligned when the low log2(N) offset bits are 0;
        // popcount-1 is exactly that low-bit mask for power-of-two sizes.
        size_m1    = pop - 4'd1;
        misalign_o = (off_i & size_m1[2:0]) != 3'b000;
        strb_o     = mask_i << off_i;
        wdata_o    = wdata_i << {off_i, 3'b000};
        rdata_o    = (rdata_i >> {off_i, 3'b000}) & byte_mask;
    end

endmodule

// File: rtl/dmem_axi_bridge.sv
// Single-outstanding load/store bridge from the memory stage to a 64-bit
// AXI4-Lite-style bus. Returns right-justified raw bytes with a one-cycle
// mem_data_ready_o pulse; misaligned accesses complete with an error and no
// bus traffic.
//   clk, rst            : clock, synchronous active-high reset
//   mem_*_i             : request from the memory stage (held until ready)
//   mem_data_ready_o    : one-cycle completion pulse
//   mem_rdata_o/err_o   : load data / error, valid with ready
//   axi_aw/w/b/ar/r_*   : AXI write address/data/response, read address/data
module dmem_axi_bridge
    import dmem_axi_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic              mem_addr_valid_i,
    input  logic [STRB_W-1:0] mem_mask_i,
    input  logic              mem_write_valid_i,
    input  logic [XLEN-1:0]   mem_wdata_i,
    output logic              mem_data_ready_o,
    output logic [XLEN-1:0]   mem_rdata_o,
    output logic              mem_err_o,
    output logic              axi_aw_valid_o,
    input  logic              axi_aw_ready_i,
    output logic [ADDR_W-1:0] axi_aw_addr_o,
    output logic              axi_w_valid_o,
    input  logic              axi_w_ready_i,
    output logic [XLEN-1:0]   axi_w_data_o,
    output logic [STRB_W-1:0] axi_w_strb_o,
    input  logic              axi_b_valid_i,
    output logic              axi_b_ready_o,
    input  logic [RESP_W-1:0] axi_b_resp_i,
    output logic              axi_ar_valid_o,
    input  logic              axi_ar_ready_i,
    output logic [ADDR_W-1:0] axi_ar_addr_o,
    input  logic              axi_r_valid_i,
    output logic              axi_r_ready_o,
    input  logic [XLEN-1:0]   axi_r_data_i,
    input  logic [RESP_W-1:0] axi_r_resp_i
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [STRB_W-1:0] mask_q, mask_d;
    logic [STRB_W-1:0] strb_q, strb_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    logic              aw_valid_q, aw_valid_d;
    logic              w_valid_q, w_valid_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              b_ready_q, b_ready_d;
    logic              ar_valid_q, ar_valid_d;
    logic              r_ready_q, r_ready_d;

    // In IDLE the aligner looks at the incoming request (misalign check and
    // store lane shift are captured into flops); afterwards it uses the
    // latched request to extract read data.
    logic              idle;
    logic [2:0]        al_off;
    logic [STRB_W-1:0] al_mask;
    logic [STRB_W-1:0] al_strb;
    logic [XLEN-1:0]   al_wdata;
    logic [XLEN-1:0]   al_rdata;
    logic              al_misalign;

    assign idle    = (state_q == ST_IDLE);
    assign al_off  = idle ? mem_addr_i[2:0] : addr_q[2:0];
    assign al_mask = idle ? mem_mask_i      : mask_q;

    dmem_align u_align (
        .off_i      (al_off),
        .mask_i     (al_mask),
        .wdata_i    (mem_wdata_i),
        .rdata_i    (axi_r_data_i),
        .strb_o     (al_strb),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata),
        .misalign_o (al_misalign)
    );

    logic aw_hs, w_hs;
    assign aw_hs = aw_valid_q & axi_aw_ready_i;
    assign w_hs  = w_valid_q & axi_w_ready_i;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        mask_d     = mask_q;
        strb_d     = strb_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        ready_d    = ready_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        b_ready_d  = b_ready_q;
        ar_valid_d = ar_valid_q;
        r_ready_d  = r_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (mem_addr_valid_i) begin
                    addr_d  = mem_addr_i;
                    mask_d  = mem_mask_i;
                    strb_d  = al_strb;
                    wdata_d = al_wdata;
                    if (al_misalign) begin
                        state_d = ST_DONE;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (mem_write_valid_i) begin
                        state_d    = ST_WR_ADDR;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        aw_done_d  = 1'b0;
                        w_done_d   = 1'b0;
                    end else begin
                        state_d    = ST_RD_ADDR;
                        ar_valid_d = 1'b1;
                    end
                end
            end
            ST_RD_ADDR: begin
                if (axi_ar_ready_i) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (axi_r_valid_i) begin
                    r_ready_d = 1'b0;
                    err_d     = (axi_r_resp_i != AXI_RESP_OKAY);
                    rdata_d   = err_d ? '0 : al_rdata;
                    ready_d   = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_WR_ADDR: begin
                if (aw_hs) begin
                    aw_valid_d = 1'b0;
                    aw_done_d  = 1'b1;
                end
                if (w_hs) begin
                    w_valid_d = 1'b0;
                    w_done_d  = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    b_ready_d = 1'b1;
                    state_d   = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (axi_b_valid_i) begin
                    b_ready_d = 1'b0;
                    err_d     = (axi_b_resp_i != AXI_RESP_OKAY);
                    rdata_d   = '0;
                    ready_d   = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                // Result is only meaningful alongside the ready pulse.
                ready_d = 1'b0;
                err_d   = 1'b0;
                rdata_d = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            mask_q     <= '0;
            strb_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            b_ready_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mask_q     <= mask_d;
            strb_q     <= strb_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            b_ready_q  <= b_ready_d;
            ar_valid_q <= ar_valid_d;
            r_ready_q  <= r_ready_d;
        end
    end

    assign mem_data_ready_o = ready_q;
    assign mem_rdata_o      = rdata_q;
    assign mem_err_o        = err_q;
    assign axi_aw_valid_o   = aw_valid_q;
    assign axi_aw_addr_o    = {addr_q[ADDR_W-1:3], 3'b000};
    assign axi_w_valid_o    = w_valid_q;
    assign axi_w_data_o     = wdata_q;
    assign axi_w_strb_o     = strb_q;
    assign axi_b_ready_o    = b_ready_q;
    assign axi_ar_valid_o   = ar_valid_q;
    assign axi_ar_addr_o    = {addr_q[ADDR_W-1:3], 3'b000};
    assign axi_r_ready_o    = r_ready_q;

endmodule
